time_counter: RTL and testbench

//  Downstream stage of the active/run handler in the two-mode timer. Counts MM:SS while Active is high.

---
 rtl/timer_pkg.sv | 24 ++
 rtl/tick_prescaler.sv | 33 +++
 rtl/time_counter.sv | 129 ++++++++++++
 tb/tb_time_counter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Purpose : shared constants and helpers for the MM:SS two-mode timer.
// Latency : n/a (package only).
// Backpressure: n/a.
package timer_pkg;

    localparam int SEC_W = 6;
    localparam int MIN_W = 7;

    localparam logic [SEC_W-1:0] MAX_SEC = 6'd59;
    localparam logic [MIN_W-1:0] MAX_MIN = 7'd99;

    localparam logic MODE_STOPWATCH = 1'b0;
    localparam logic MODE_COUNTDOWN = 1'b1;

    // Out-of-range presets saturate to the largest legal value.
    function automatic logic [SEC_W-1:0] clamp_sec(input logic [SEC_W-1:0] s);
        return (s > MAX_SEC) ? MAX_SEC : s;
    endfunction

    function automatic logic [MIN_W-1:0] clamp_min(input logic [MIN_W-1:0] m);
        return (m > MAX_MIN) ? MAX_MIN : m;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Purpose : divides clk down to a one-cycle tick every TICK_DIV enabled cycles.
// Latency : first tick on the TICK_DIV-th enabled cycle after clr; tick is combinational from the count.
// Backpressure: none; en=0 freezes the count so a partial period is preserved.
// Ports: clk, rst (async active-low), clr (sync clear, wins over en), en (advance), tick (out).
module tick_prescaler #(
    parameter int TICK_DIV = 50_000_000,
    parameter int CNT_W    = 26
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    logic [CNT_W-1:0] cnt;
    logic             at_top;

    assign at_top = (cnt == CNT_W'(TICK_DIV - 1));
    // Gate with en/clr so a count parked at the top while paused does not re-fire.
    assign tick   = at_top & en & ~clr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= at_top ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/time_counter.sv
// Purpose : MM:SS stopwatch (up) / countdown (down) counter with terminal-count flag.
// Latency : count updates on the tick edge; StopCondition one cycle after terminal count.
// Backpressure: none; Active=0 pauses the prescaler, resetter reloads every cycle it is held.
// Ports: clk, rst (async active-low), resetter, Active, ModeSel, PresetMin, PresetSec, Lap
//        -> Minutes, Seconds, StopCondition.
// Build option: TIMER_LAP_EN adds a lap-hold register on the displayed value; otherwise Lap is ignored.
module time_counter
    import timer_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000,
    parameter int CNT_W    = 26
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             resetter,
    input  logic             Active,
    input  logic             ModeSel,
    input  logic [MIN_W-1:0] PresetMin,
    input  logic [SEC_W-1:0] PresetSec,
    input  logic             Lap,
    output logic [MIN_W-1:0] Minutes,
    output logic [SEC_W-1:0] Seconds,
    output logic             StopCondition
);

    logic             tick;
    logic [MIN_W-1:0] min_q, min_nxt;
    logic [SEC_W-1:0] sec_q, sec_nxt;
    logic             at_terminal;
    logic             stop_q;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV),
        .CNT_W    (CNT_W)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (resetter),
        .en   (Active),
        .tick (tick)
    );

    // Next-state of the live count: resetter load > tick step > hold.
    always_comb begin
        min_nxt = min_q;
        sec_nxt = sec_q;
        if (resetter) begin
            if (ModeSel == MODE_COUNTDOWN) begin
                min_nxt = clamp_min(PresetMin);
                sec_nxt = clamp_sec(PresetSec);
            end else begin
                min_nxt = '0;
                sec_nxt = '0;
            end
        end else if (tick) begin
            if (ModeSel == MODE_STOPWATCH) begin
                if (sec_q < MAX_SEC) begin
                    sec_nxt = sec_q + 1'b1;
                end else if (min_q < MAX_MIN) begin
                    sec_nxt = '0;
                    min_nxt = min_q + 1'b1;
                end
                // 99:59 saturates: both stay as they are.
            end else begin
                if (sec_q != '0) begin
                    sec_nxt = sec_q - 1'b1;
                end else if (min_q != '0) begin
                    sec_nxt = MAX_SEC;
                    min_nxt = min_q - 1'b1;
                end
                // 00:00 holds: no underflow.
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            min_q <= '0;
            sec_q <= '0;
        end else begin
            min_q <= min_nxt;
            sec_q <= sec_nxt;
        end
    end

    // Terminal value follows the current direction, so a live mode flip retargets it.
    assign at_terminal = (ModeSel == MODE_COUNTDOWN)
                       ? ((min_q == '0) && (sec_q == '0))
                       : ((min_q == MAX_MIN) && (sec_q == MAX_SEC));

    // Sticky until resetter/rst; Active dropping must not clear it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stop_q <= 1'b0;
        end else if (resetter) begin
            stop_q <= 1'b0;
        end else if (at_terminal) begin
            stop_q <= 1'b1;
        end
    end

    assign StopCondition = stop_q;

`ifdef TIMER_LAP_EN
    logic [MIN_W-1:0] lap_min;
    logic [SEC_W-1:0] lap_sec;

    // Tracks the next live value so the display has no lag while Lap=0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lap_min <= '0;
            lap_sec <= '0;
        end else if (resetter || !Lap) begin
            lap_min <= min_nxt;
            lap_sec <= sec_nxt;
        end
    end

    assign Minutes = lap_min;
    assign Seconds = lap_sec;
`else
    logic unused_lap;
    assign unused_lap = Lap;

    assign Minutes = min_q;
    assign Seconds = sec_q;
`endif

endmodule

// File: tb/tb_time_counter.sv
// Directed bench for time_counter with TICK_DIV=4; inputs driven and outputs sampled 1 time unit after posedge.
module tb_time_counter;
    import timer_pkg::*;

    logic             clk;
    logic             rst;
    logic             resetter;
    logic             Active;
    logic             ModeSel;
    logic [MIN_W-1:0] PresetMin;
    logic [SEC_W-1:0] PresetSec;
    logic             Lap;
    logic [MIN_W-1:0] Minutes;
    logic [SEC_W-1:0] Seconds;
    logic             StopCondition;

    int n_cmp;
    int n_bad;

    time_counter #(
        .TICK_DIV (4),
        .CNT_W    (3)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .resetter      (resetter),
        .Active        (Active),
        .ModeSel       (ModeSel),
        .PresetMin     (PresetMin),
        .PresetSec     (PresetSec),
        .Lap           (Lap),
        .Minutes       (Minutes),
        .Seconds       (Seconds),
        .StopCondition (StopCondition)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_time(input string tag, input int m, input int s, input int sc);
        check({tag, ".min"}, int'(Minutes), m);
        check({tag, ".sec"}, int'(Seconds), s);
        check({tag, ".stop"}, int'(StopCondition), sc);
    endtask

    // Advance n rising edges and land 1 unit after the last one.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load(input logic mode, input int m, input int s);
        ModeSel   = mode;
        PresetMin = MIN_W'(m);
        PresetSec = SEC_W'(s);
        resetter  = 1'b1;
        cyc(1);
        resetter  = 1'b0;
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        rst       = 1'b0;
        resetter  = 1'b0;
        Active    = 1'b0;
        ModeSel   = MODE_STOPWATCH;
        PresetMin = '0;
        PresetSec = '0;
        Lap       = 1'b0;

        #1;
        check_time("reset", 0, 0, 0);
        cyc(2);
        rst = 1'b1;
        cyc(1);
        check_time("idle", 0, 0, 0);

        // Stopwatch: 244 active cycles = 61 ticks = 01:01
        load(MODE_STOPWATCH, 0, 0);
        check_time("sw.load", 0, 0, 0);
        Active = 1'b1;
        cyc(3);
        check_time("sw.pre_tick", 0, 0, 0);
        cyc(1);
        check_time("sw.t1", 0, 1, 0);
        cyc(232);
        check_time("sw.t59", 0, 59, 0);
        cyc(4);
        check_time("sw.wrap", 1, 0, 0);
        cyc(4);
        check_time("sw.t61", 1, 1, 0);
        Active = 1'b0;

        // Pause preserves partial second
        load(MODE_STOPWATCH, 0, 0);
        Active = 1'b1;
        cyc(4);
        check_time("pause.t1", 0, 1, 0);
        cyc(2);
        Active = 1'b0;
        cyc(20);
        check_time("pause.hold", 0, 1, 0);
        Active = 1'b1;
        cyc(1);
        check_time("pause.res1", 0, 1, 0);
        cyc(1);
        check_time("pause.res2", 0, 2, 0);
        Active = 1'b0;

        // Countdown expiry from 00:02
        load(MODE_COUNTDOWN, 0, 2);
        check_time("cd.load", 0, 2, 0);
        Active = 1'b1;
        cyc(4);
        check_time("cd.t1", 0, 1, 0);
        cyc(4);
        check_time("cd.zero", 0, 0, 0);
        cyc(1);
        check_time("cd.stop", 0, 0, 1);
        Active = 1'b0;
        cyc(5);
        check_time("cd.stop_held", 0, 0, 1);

        // Clamping
        load(MODE_COUNTDOWN, 120, 63);
        check_time("clamp", 99, 59, 0);

        // resetter beats a coincident tick and clears the prescaler
        load(MODE_COUNTDOWN, 0, 5);
        Active = 1'b1;
        cyc(3);
        check_time("prio.pre", 0, 5, 0);
        resetter = 1'b1;
        cyc(1);
        check_time("prio.load", 0, 5, 0);
        resetter = 1'b0;
        cyc(3);
        check_time("prio.after3", 0, 5, 0);
        cyc(1);
        check_time("prio.after4", 0, 4, 0);
        Active = 1'b0;

        // Countdown preset 00:00 flags one cycle after release
        load(MODE_COUNTDOWN, 0, 0);
        check_time("zero.load", 0, 0, 0);
        cyc(1);
        check_time("zero.stop", 0, 0, 1);
        resetter = 1'b1;
        cyc(1);
        check_time("zero.clear", 0, 0, 0);
        resetter = 1'b0;

        // Saturation: preload 99:58 via countdown, then count up from it
        ModeSel   = MODE_COUNTDOWN;
        PresetMin = 7'd99;
        PresetSec = 6'd58;
        resetter  = 1'b1;
        cyc(1);
        resetter  = 1'b0;
        ModeSel   = MODE_STOPWATCH;
        Active    = 1'b1;
        cyc(4);
        check_time("sat.top", 99, 59, 0);
        cyc(1);
        check_time("sat.stop", 99, 59, 1);
        cyc(8);
        check_time("sat.hold", 99, 59, 1);
        Active = 1'b0;

        // Lap hold at 00:03 for 8 cycles
        load(MODE_STOPWATCH, 0, 0);
        Active = 1'b1;
        cyc(12);
        check_time("lap.pre", 0, 3, 0);
        Lap = 1'b1;
        cyc(8);
`ifdef TIMER_LAP_EN
        check_time("lap.frozen", 0, 3, 0);
        Lap = 1'b0;
        cyc(1);
        check_time("lap.release", 0, 5, 0);
`else
        check_time("lap.ignored", 0, 5, 0);
        Lap = 1'b0;
`endif
        Active = 1'b0;

        // Async reset mid-count at 12:34
        load(MODE_COUNTDOWN, 12, 34);
        check_time("ar.load", 12, 34, 0);
        Active = 1'b1;
        cyc(6);
        check_time("ar.run", 12, 33, 0);
        #2;
        rst = 1'b0;
        #1;
        check_time("ar.async", 0, 0, 0);
        cyc(1);
        Active  = 1'b0;
        ModeSel = MODE_STOPWATCH;
        rst     = 1'b1;
        cyc(1);
        check_time("ar.idle", 0, 0, 0);
        Active = 1'b1;
        cyc(3);
        check_time("ar.pre", 0, 0, 0);
        cyc(1);
        check_time("ar.t1", 0, 1, 0);
        Active = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
